// File: rtl/medium_arbiter.sv
// medium_arbiter
//   Two-port arbiter in front of a single shared memory-like medium. Each
//   port presents one access (read or write) at a time; the arbiter grants
//   one port, issues exactly one command to the medium wrapper, waits for
//   its completion pulse (or a timeout), reports completion to the granted
//   port and returns to IDLE. Only one access is ever outstanding.
//
// Ports
//   clk_in, rst_in           clock, synchronous active-high reset
//   pN_valid/write/addr/wdata  port N request (N = 0, 1)
//   pN_ready                 port N request accepted this cycle
//   pN_done                  one-cycle completion pulse for port N
//   pN_rdata                 last data read on behalf of port N
//   med_addr/med_din         address / write data to the medium wrapper
//   med_read_enable          one-cycle read command
//   med_write_enable         one-cycle write command
//   med_dout/med_finished    read data / one-cycle completion from wrapper
//   busy                     high whenever the FSM is not IDLE
//   timeout_err              sticky: an access was aborted by timeout
//   state_dbg                current FSM state (IDLE=0 ISSUE=1 WAIT=2 RESP=3)
//
// Handshake: a request transfers on a rising edge where pN_valid and
// pN_ready are both high. pN_ready is only ever high in IDLE, for at most
// one port, and only while that port's valid is high; a port may drop
// valid before it is accepted with no effect. Once accepted, the request
// fields are captured and the port inputs are not looked at again until
// the FSM is back in IDLE.

module medium_arbiter #(
  parameter int ADDR_SIZE = 10,
  parameter int WIDTH     = 2048,
  parameter int TIMEOUT   = 4096
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 p0_valid,
  input  logic                 p0_write,
  input  logic [ADDR_SIZE-1:0] p0_addr,
  input  logic [WIDTH-1:0]     p0_wdata,
  output logic                 p0_ready,
  output logic                 p0_done,
  output logic [WIDTH-1:0]     p0_rdata,
  input  logic                 p1_valid,
  input  logic                 p1_write,
  input  logic [ADDR_SIZE-1:0] p1_addr,
  input  logic [WIDTH-1:0]     p1_wdata,
  output logic                 p1_ready,
  output logic                 p1_done,
  output logic [WIDTH-1:0]     p1_rdata,
  output logic [ADDR_SIZE-1:0] med_addr,
  output logic [WIDTH-1:0]     med_din,
  output logic                 med_read_enable,
  output logic                 med_write_enable,
  input  logic [WIDTH-1:0]     med_dout,
  input  logic                 med_finished,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             last_q;   // port granted most recently
  logic             gnt_q;    // port owning the current access
  logic             wr_q;     // current access is a write
  logic             sel;      // port that would win arbitration now
  logic             xfer;
  logic             timeout_hit;

  // A lone requester wins; on a tie the port not granted last wins.
  assign sel  = p1_valid && (!p0_valid || !last_q);
  assign xfer = p0_ready || p1_ready;

  // Completion on the final counted cycle takes priority over the abort.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1)) && !med_finished;

  always_comb begin
    state_d          = state_q;
    p0_ready         = 1'b0;
    p1_ready         = 1'b0;
    p0_done          = 1'b0;
    p1_done          = 1'b0;
    med_read_enable  = 1'b0;
    med_write_enable = 1'b0;
    case (state_q)
      IDLE: begin
        p0_ready = p0_valid && !sel;
        p1_ready = p1_valid && sel;
        if (p0_ready || p1_ready) state_d = ISSUE;
      end
      ISSUE: begin
        med_write_enable = wr_q;
        med_read_enable  = !wr_q;
        state_d          = WAIT;
      end
      WAIT: begin
        if (med_finished || timeout_hit) state_d = RESP;
      end
      RESP: begin
        p0_done = !gnt_q;
        p1_done = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      gnt_q       <= 1'b0;
      wr_q        <= 1'b0;
      med_addr    <= '0;
      med_din     <= '0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE && xfer) begin
        gnt_q    <= sel;
        wr_q     <= sel ? p1_write : p0_write;
        med_addr <= sel ? p1_addr  : p0_addr;
        med_din  <= sel ? p1_wdata : p0_wdata;
      end

      if (state_q == WAIT) cnt_q <= cnt_q + CNT_W'(1);
      else                 cnt_q <= '0;

      if (state_q == WAIT && med_finished && !wr_q) begin
        if (gnt_q) p1_rdata <= med_dout;
        else       p0_rdata <= med_dout;
      end

      if (state_q == WAIT && timeout_hit) timeout_err <= 1'b1;

      if (state_q == RESP) last_q <= gnt_q;
    end
  end

endmodule

// File: tb/tb_medium_arbiter.sv
// tb_medium_arbiter
//   Bench for medium_arbiter with a cycle-stepped medium wrapper model.
//   Directed scenarios (reset, read latency, write, timeout boundary,
//   timeout abort, reset mid-access, round-robin) followed by a randomized
//   run checked against a transaction-level model: expected grant winner,
//   done cycle = transfer + 2 + k, and read data through exp_q.

module tb_medium_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int TO = 70;

  // ---------------------------------------------------------------- clock/reset
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic          rst_in = 1'b1;
  logic          p0_valid = 0, p0_write = 0, p1_valid = 0, p1_write = 0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0;
  logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_ready, p0_done, p1_ready, p1_done;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] med_addr;
  logic [DW-1:0] med_din;
  logic          med_read_enable, med_write_enable;
  logic [DW-1:0] med_dout = '0;
  logic          med_finished = 1'b0;
  logic          busy, timeout_err;
  logic [1:0]    state_dbg;

  medium_arbiter #(.ADDR_SIZE(AW), .WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .p0_valid(p0_valid), .p0_write(p0_write), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ready(p0_ready), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_write(p1_write), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ready(p1_ready), .p1_done(p1_done), .p1_rdata(p1_rdata),
    .med_addr(med_addr), .med_din(med_din),
    .med_read_enable(med_read_enable), .med_write_enable(med_write_enable),
    .med_dout(med_dout), .med_finished(med_finished),
    .busy(busy), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // ---------------------------------------------------------------- bookkeeping
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // medium wrapper model: finishes wrap_k cycles after the enable (0 = never)
  int            wrap_k = 1;
  logic [DW-1:0] wrap_data = '0;
  bit            pend = 0, fin_never = 0, force_fin = 0;
  int            fin_at = 0;

  int proto_viol = 0;
  int cmd_cnt = 0;
  int cmd_addr_q[$];
  int grant_log[$];
  int done_cnt0 = 0, done_cnt1 = 0;

  logic [DW-1:0] mdl_rd[2];
  logic [DW-1:0] exp_q[$];

  // ---------------------------------------------------------------- driver tasks
  // Advance one clock; afterwards we sit 1 time unit past the edge, outputs
  // settled, and the wrapper model has reacted to this cycle's commands.
  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
    if (rst_in) pend = 0;
    med_finished = 1'b0;
    if (med_read_enable || med_write_enable) begin
      if (pend || (med_read_enable && med_write_enable)) proto_viol++;
      pend = 1;
      fin_never = (wrap_k == 0);
      fin_at = cyc + wrap_k;
      cmd_cnt++;
      cmd_addr_q.push_back(int'(med_addr));
    end
    if (pend && !fin_never && cyc == fin_at) begin
      med_finished = 1'b1; med_dout = wrap_data; pend = 0;
    end
    if (force_fin) begin
      med_finished = 1'b1; med_dout = wrap_data;
    end
    if (p0_done && p1_done) proto_viol++;
    if (p0_done) begin done_cnt0++; grant_log.push_back(0); pend = 0; end
    if (p1_done) begin done_cnt1++; grant_log.push_back(1); pend = 0; end
  endtask

  task automatic do_reset();
    p0_valid = 0; p1_valid = 0; force_fin = 0;
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    pend = 0;
    mdl_rd[0] = '0; mdl_rd[1] = '0;
  endtask

  // ---------------------------------------------------------------- scenarios
  task automatic test_reset();
    p0_valid = 0; p1_valid = 0; rst_in = 1'b1;
    step(); step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err got=%b exp=0", timeout_err); end
    checks++; if (p0_rdata !== '0 || p1_rdata !== '0) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0/0", p0_rdata, p1_rdata); end
    checks++; if (med_addr !== '0 || med_din !== '0) begin errors++; $display("FAIL reset_med_bus got=%h/%h exp=0/0", med_addr, med_din); end
    checks++; if ({med_read_enable, med_write_enable, p0_done, p1_done} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses got=%b exp=0000", {med_read_enable, med_write_enable, p0_done, p1_done}); end
    rst_in = 1'b0;
    mdl_rd[0] = '0; mdl_rd[1] = '0;
    // Peek at the first tie: port 0 must win; drop valid before the edge.
    p0_valid = 1; p1_valid = 1;
    #1;
    checks++; if ({p0_ready, p1_ready} !== 2'b10) begin errors++; $display("FAIL first_tie_ready got=%b exp=10", {p0_ready, p1_ready}); end
    p0_valid = 0; p1_valid = 0;
    step();
    checks++; if (busy !== 1'b0 || cmd_cnt != 0) begin errors++; $display("FAIL dropped_valid got busy=%b cmds=%0d exp=0/0", busy, cmd_cnt); end
  endtask

  task automatic test_read_latency();
    int t, n, base_cmd, base_done, done_c, addr_bad;
    logic [DW-1:0] pat;
    pat = {4{8'hA5}};
    wrap_k = 66; wrap_data = pat;
    base_cmd = cmd_cnt; base_done = done_cnt0; addr_bad = 0;
    p0_valid = 1; p0_write = 0; p0_addr = 6'd5; p0_wdata = $urandom;
    #1;
    checks++; if ({p0_ready, p1_ready} !== 2'b10) begin errors++; $display("FAIL rd_ready got=%b exp=10", {p0_ready, p1_ready}); end
    t = cyc;
    step();
    p0_valid = 0;
    checks++; if ({med_read_enable, med_write_enable} !== 2'b10 || med_addr !== 6'd5) begin
      errors++; $display("FAIL rd_issue got en=%b addr=%0d exp en=10 addr=5", {med_read_enable, med_write_enable}, med_addr); end
    n = 0;
    while (!p0_done && n < 200) begin
      step(); n++;
      if (med_addr !== 6'd5) addr_bad++;
    end
    done_c = cyc;
    checks++; if (!p0_done || done_c != t + 68) begin errors++; $display("FAIL rd_done_cycle got=%0d exp=%0d", done_c - t, 68); end
    checks++; if (p0_rdata !== pat) begin errors++; $display("FAIL rd_data got=%h exp=%h", p0_rdata, pat); end
    checks++; if (addr_bad != 0) begin errors++; $display("FAIL rd_addr_stable got=%0d bad cycles exp=0", addr_bad); end
    mdl_rd[0] = pat;
    step();
    checks++; if (p0_done !== 1'b0 || done_cnt0 - base_done != 1) begin errors++; $display("FAIL rd_done_pulse got=%0d pulses exp=1", done_cnt0 - base_done); end
    checks++; if (cmd_cnt - base_cmd != 1) begin errors++; $display("FAIL rd_cmd_count got=%0d exp=1", cmd_cnt - base_cmd); end
    checks++; if (p1_rdata !== mdl_rd[1] || busy !== 1'b0) begin errors++; $display("FAIL rd_p1_untouched got=%h busy=%b exp=%h busy=0", p1_rdata, busy, mdl_rd[1]); end
  endtask

  task automatic test_write();
    int t, n, k, din_bad, wen;
    logic [DW-1:0] d;
    d = $urandom; k = $urandom_range(1, 10);
    wrap_k = k; wrap_data = $urandom;
    din_bad = 0; wen = 0;
    p1_valid = 1; p1_write = 1; p1_addr = 6'd3; p1_wdata = d;
    #1;
    checks++; if ({p0_ready, p1_ready} !== 2'b01) begin errors++; $display("FAIL wr_ready got=%b exp=01", {p0_ready, p1_ready}); end
    t = cyc;
    step();
    p1_valid = 0; p1_wdata = ~d;
    checks++; if ({med_read_enable, med_write_enable} !== 2'b01) begin
      errors++; $display("FAIL wr_issue got en=%b exp=01", {med_read_enable, med_write_enable}); end
    if (med_din !== d || med_addr !== 6'd3) din_bad++;
    n = 0;
    while (!p1_done && n < 50) begin
      step(); n++;
      if (med_write_enable) wen++;
      if (med_din !== d || med_addr !== 6'd3) din_bad++;
    end
    checks++; if (!p1_done || cyc != t + 2 + k) begin errors++; $display("FAIL wr_done_cycle got=%0d exp=%0d", cyc - t, 2 + k); end
    checks++; if (din_bad != 0 || wen != 0) begin errors++; $display("FAIL wr_din_held got bad=%0d extra_en=%0d exp=0/0", din_bad, wen); end
    checks++; if (p1_rdata !== mdl_rd[1] || p0_rdata !== mdl_rd[0]) begin
      errors++; $display("FAIL wr_rdata_unchanged got=%h/%h exp=%h/%h", p0_rdata, p1_rdata, mdl_rd[0], mdl_rd[1]); end
    step();
  endtask

  task automatic test_timeout();
    int t, n;
    logic [DW-1:0] x;
    // Completion on the last counted WAIT cycle: completes, no error.
    x = $urandom; wrap_k = TO; wrap_data = x;
    p0_valid = 1; p0_write = 0; p0_addr = $urandom;
    #1; t = cyc;
    step(); p0_valid = 0;
    n = 0; while (!p0_done && n < TO + 20) begin step(); n++; end
    checks++; if (!p0_done || cyc != t + 2 + TO) begin errors++; $display("FAIL to_edge_done got=%0d exp=%0d", cyc - t, 2 + TO); end
    checks++; if (timeout_err !== 1'b0 || p0_rdata !== x) begin errors++; $display("FAIL to_edge_result got err=%b data=%h exp err=0 data=%h", timeout_err, p0_rdata, x); end
    mdl_rd[0] = x;
    step();
    // Wrapper never answers: abort after TO WAIT cycles.
    wrap_k = 0; wrap_data = ~x;
    p0_valid = 1; p0_write = 0; p0_addr = $urandom;
    #1; t = cyc;
    step(); p0_valid = 0;
    n = 0; while (!p0_done && n < TO + 20) begin step(); n++; end
    checks++; if (!p0_done || cyc != t + 2 + TO) begin errors++; $display("FAIL to_abort_done got=%0d exp=%0d", cyc - t, 2 + TO); end
    checks++; if (timeout_err !== 1'b1 || p0_rdata !== mdl_rd[0]) begin errors++; $display("FAIL to_abort_result got err=%b data=%h exp err=1 data=%h", timeout_err, p0_rdata, mdl_rd[0]); end
    step(); step();
    // Next request serviced normally; error stays sticky.
    x = $urandom; wrap_k = 3; wrap_data = x;
    p1_valid = 1; p1_write = 0; p1_addr = $urandom;
    #1; t = cyc;
    step(); p1_valid = 0;
    n = 0; while (!p1_done && n < 20) begin step(); n++; end
    checks++; if (!p1_done || cyc != t + 5 || p1_rdata !== x) begin errors++; $display("FAIL to_recover got dt=%0d data=%h exp dt=5 data=%h", cyc - t, p1_rdata, x); end
    checks++; if (timeout_err !== 1'b1 || proto_viol != 0) begin errors++; $display("FAIL to_sticky got err=%b viol=%0d exp err=1 viol=0", timeout_err, proto_viol); end
    mdl_rd[1] = x;
    step();
  endtask

  task automatic test_reset_mid_wait();
    int t, n, d0, d1;
    logic [DW-1:0] z;
    wrap_k = 0; wrap_data = $urandom;
    p1_valid = 1; p1_write = 0; p1_addr = 6'd7;
    #1;
    step(); p1_valid = 0;
    repeat (5) step();
    d0 = done_cnt0; d1 = done_cnt1;
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    mdl_rd[0] = '0; mdl_rd[1] = '0;
    checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL rstw_status got busy=%b err=%b exp=0/0", busy, timeout_err); end
    checks++; if ({med_read_enable, med_write_enable, p0_done, p1_done} !== 4'b0 || med_addr !== '0 || med_din !== '0) begin
      errors++; $display("FAIL rstw_outputs got pulses=%b addr=%h din=%h exp=0", {med_read_enable, med_write_enable, p0_done, p1_done}, med_addr, med_din); end
    checks++; if (p0_rdata !== '0 || p1_rdata !== '0) begin errors++; $display("FAIL rstw_rdata got=%h/%h exp=0/0", p0_rdata, p1_rdata); end
    // A stray completion after the reset must be ignored.
    force_fin = 1; wrap_data = $urandom;
    step();
    force_fin = 0;
    step(); step();
    checks++; if (busy !== 1'b0 || done_cnt0 != d0 || done_cnt1 != d1 || p1_rdata !== '0) begin
      errors++; $display("FAIL rstw_late_fin got busy=%b dones=%0d rdata=%h exp busy=0 dones=0 rdata=0", busy, done_cnt0 + done_cnt1 - d0 - d1, p1_rdata); end
    z = $urandom; wrap_k = 4; wrap_data = z;
    p1_valid = 1; p1_write = 0; p1_addr = $urandom;
    #1; t = cyc;
    step(); p1_valid = 0;
    n = 0; while (!p1_done && n < 20) begin step(); n++; end
    checks++; if (!p1_done || cyc != t + 6 || p1_rdata !== z) begin errors++; $display("FAIL rstw_fresh got dt=%0d data=%h exp dt=6 data=%h", cyc - t, p1_rdata, z); end
    mdl_rd[1] = z;
    step();
  endtask

  task automatic test_round_robin();
    int n, base_g, base_c;
    do_reset();
    proto_viol = 0;
    base_g = grant_log.size(); base_c = cmd_addr_q.size();
    wrap_k = 2; wrap_data = 32'h1234_5678;
    p0_valid = 1; p0_write = 0; p0_addr = 6'd10;
    p1_valid = 1; p1_write = 0; p1_addr = 6'd20;
    n = 0;
    while (grant_log.size() < base_g + 4 && n < 200) begin step(); n++; end
    p0_valid = 0; p1_valid = 0;
    checks++; if (grant_log.size() < base_g + 4) begin errors++; $display("FAIL rr_progress got=%0d exp=4", grant_log.size() - base_g); end
    else begin
      checks++; if (grant_log[base_g] != 0 || grant_log[base_g+1] != 1 || grant_log[base_g+2] != 0 || grant_log[base_g+3] != 1) begin
        errors++; $display("FAIL rr_done_order got=%0d%0d%0d%0d exp=0101", grant_log[base_g], grant_log[base_g+1], grant_log[base_g+2], grant_log[base_g+3]); end
      checks++; if (cmd_addr_q[base_c] != 10 || cmd_addr_q[base_c+1] != 20 || cmd_addr_q[base_c+2] != 10 || cmd_addr_q[base_c+3] != 20) begin
        errors++; $display("FAIL rr_cmd_order got=%0d,%0d,%0d,%0d exp=10,20,10,20", cmd_addr_q[base_c], cmd_addr_q[base_c+1], cmd_addr_q[base_c+2], cmd_addr_q[base_c+3]); end
    end
    checks++; if (proto_viol != 0) begin errors++; $display("FAIL rr_one_outstanding got=%0d violations exp=0", proto_viol); end
    step(); step();
  endtask

  task automatic test_random();
    bit            rv[2], rw[2];
    logic [AW-1:0] ra[2];
    logic [DW-1:0] rd[2];
    bit            last_m, idle, exp_r0, exp_r1, done_wr;
    int            idle_at, done_at, done_port, xfer_at, k, p;
    logic [DW-1:0] got;
    do_reset();
    proto_viol = 0;
    exp_q.delete();
    last_m = 1; idle_at = cyc; done_at = -1; done_port = 0; xfer_at = -1; done_wr = 0;
    rv[0] = 0; rv[1] = 0;
    for (int i = 0; i < 450; i++) begin
      // outputs that do not depend on this cycle's inputs
      checks++; if (busy !== ((cyc > xfer_at) && (cyc < idle_at))) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b", cyc, busy); end
      checks++; if ({p0_done, p1_done} !== {cyc == done_at && done_port == 0, cyc == done_at && done_port == 1}) begin
        errors++; $display("FAIL rnd_done cyc=%0d got=%b exp_port=%0d at=%0d", cyc, {p0_done, p1_done}, done_port, done_at); end
      if (cyc == done_at && !done_wr) begin
        if (exp_q.size() == 0) begin checks++; errors++; $display("FAIL rnd_scoreboard_empty cyc=%0d", cyc); end
        else mdl_rd[done_port] = exp_q.pop_front();
      end
      checks++; if (p0_rdata !== mdl_rd[0] || p1_rdata !== mdl_rd[1]) begin
        errors++; $display("FAIL rnd_rdata cyc=%0d got=%h/%h exp=%h/%h", cyc, p0_rdata, p1_rdata, mdl_rd[0], mdl_rd[1]); end
      // new stimulus: hold pending requests, occasionally drop or raise one
      for (int j = 0; j < 2; j++) begin
        if (i >= 400) rv[j] = 0;
        else if (!rv[j]) begin
          if ($urandom_range(0, 9) < 5) begin
            rv[j] = 1; rw[j] = $urandom_range(0, 1); ra[j] = $urandom; rd[j] = $urandom;
          end
        end else if ($urandom_range(0, 19) == 0) rv[j] = 0;
      end
      p0_valid = rv[0]; p0_write = rw[0]; p0_addr = ra[0]; p0_wdata = rd[0];
      p1_valid = rv[1]; p1_write = rw[1]; p1_addr = ra[1]; p1_wdata = rd[1];
      #1;
      idle   = (cyc >= idle_at);
      exp_r0 = idle && rv[0] && (!rv[1] || last_m);
      exp_r1 = idle && rv[1] && (!rv[0] || !last_m);
      checks++; if ({p0_ready, p1_ready} !== {exp_r0, exp_r1}) begin
        errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, {p0_ready, p1_ready}, {exp_r0, exp_r1}); end
      if (exp_r0 || exp_r1) begin
        p = exp_r1 ? 1 : 0;
        k = $urandom_range(1, 12);
        wrap_k = k; wrap_data = $urandom;
        done_wr = rw[p];
        if (!rw[p]) exp_q.push_back(wrap_data);
        xfer_at = cyc; done_at = cyc + 2 + k; idle_at = done_at + 1;
        done_port = p; last_m = (p == 1);
        rv[p] = 0;
      end
      step();
    end
    checks++; if (exp_q.size() != 0 || proto_viol != 0) begin
      errors++; $display("FAIL rnd_drain got pending=%0d viol=%0d exp=0/0", exp_q.size(), proto_viol); end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    test_reset();
    test_read_latency();
    test_write();
    test_timeout();
    test_reset_mid_wait();
    test_round_robin();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
